// File: rtl/facto_pkg.sv
// ============================================================================
// Module      : facto_pkg
// Description : Shared state encoding and result-word split constants for the
//               factorial controller and its shift-add multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package facto_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int c_width_default = 64;

    // The controller splits the product into two WIDTH-bit words.
    localparam int c_res_hi_msb = 2*c_width_default - 1;
    localparam int c_res_hi_lsb = c_width_default;
    localparam int c_res_lo_msb = c_width_default - 1;
    localparam int c_res_lo_lsb = 0;

endpackage : facto_pkg

`default_nettype wire

// File: rtl/facto_multiplier.sv
// ============================================================================
// Module      : facto_multiplier
// Description : Iterative unsigned shift-add multiplier with fixed WIDTH-cycle
//               latency, driven by the factorial controller via start/clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module facto_multiplier
    import facto_pkg::*;
#(
    parameter int WIDTH = c_width_default,
    parameter int CNT_W = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 clear,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [2*WIDTH-1:0]   result,
    output logic                 done,
    output logic                 busy
);

    state_t               r_state;
    state_t               w_state_next;
    logic [WIDTH-1:0]     r_mcand;
    logic [2*WIDTH:0]     r_acc;
    logic [CNT_W-1:0]     r_cnt;
    logic [2*WIDTH-1:0]   r_result;
    logic                 r_done;
    logic                 r_busy;

    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH:0]     w_acc_step;
    logic [2*WIDTH:0]     w_acc_next;
    logic                 w_last;
    logic                 w_load;
    logic                 w_step;

    // Upper half plus multiplicand; the carry lands in acc[2*WIDTH] before the shift.
    assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand};
    assign w_acc_step = r_acc[0] ? {w_sum, r_acc[WIDTH-1:0]} : r_acc;
    assign w_acc_next = w_acc_step >> 1;
    assign w_last     = (r_cnt == CNT_W'(WIDTH-1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        if (clear) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        w_load       = 1'b1;
                        w_state_next = EXEC;
                    end
                end
                EXEC: begin
                    w_step = 1'b1;
                    if (w_last) begin
                        w_state_next = DONE;
                    end
                end
                DONE:    w_state_next = DONE;
                default: w_state_next = IDLE;
            endcase
        end
    end

    // Clear leaves mcand/acc stale: they are fully reloaded on the next accepted start.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mcand  <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else if (clear) begin
            r_cnt    <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else if (w_load) begin
            r_mcand  <= multiplicand;
            r_acc    <= {{(WIDTH+1){1'b0}}, multiplier};
            r_cnt    <= '0;
            r_busy   <= 1'b1;
        end else if (w_step) begin
            r_acc    <= w_acc_next;
            r_cnt    <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_result <= w_acc_next[2*WIDTH-1:0];
                r_done   <= 1'b1;
                r_busy   <= 1'b0;
            end
        end
    end

    assign result = r_result;
    assign done   = r_done;
    assign busy   = r_busy;

endmodule : facto_multiplier

`default_nettype wire

// File: tb/tb_facto_multiplier.sv
// ============================================================================
// Module      : tb_facto_multiplier
// Description : Scoreboard-driven bench for facto_multiplier, including a
//               bench-as-controller factorial chain.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_facto_multiplier;

    localparam int c_lat    = 64;
    localparam int c_budget = 100;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic           clear;
    logic [63:0]    multiplicand;
    logic [63:0]    multiplier;
    logic [127:0]   result;
    logic           done;
    logic           busy;

    logic [127:0]   exp_q[$];
    int             errors = 0;
    int             checks = 0;

    facto_multiplier #(.WIDTH(64), .CNT_W(7)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .clear        (clear),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .result       (result),
        .done         (done),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive a one-cycle start and record the expected product; returns just after the accepting edge.
    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [127:0] exp_val);
        @(negedge clk);
        start        = 1'b1;
        multiplicand = a;
        multiplier   = b;
        exp_q.push_back(exp_val);
        @(negedge clk);
        start        = 1'b0;
        multiplicand = $urandom();
        multiplier   = $urandom();
    endtask

    // Count edges until done rises; optional start/operand noise while in EXEC.
    task automatic wait_done(input bit noise, output int lat);
        bit seen = 1'b0;
        lat = -1;
        for (int n = 1; n <= c_budget && !seen; n++) begin
            @(negedge clk);
            if (done) begin
                lat  = n;
                seen = 1'b1;
            end else if (noise && n >= 10 && n < 15) begin
                start        = 1'b1;
                multiplicand = {$urandom(), $urandom()};
                multiplier   = {$urandom(), $urandom()};
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        start = 1'b0; clear = 1'b0; multiplicand = '0; multiplier = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checks++;
        if (result !== 128'd0 || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset: result=%0h done=%b busy=%b, required 0/0/0", result, done, busy);
        end
    endtask

    task automatic test_basic();
        int lat;
        logic [127:0] e;
        issue(64'd3, 64'd4, 128'd12);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy: busy=%b done=%b, required 1/0", busy, done);
        end
        wait_done(1'b0, lat);
        e = exp_q.pop_front();
        checks++;
        if (lat !== c_lat) begin
            errors++;
            $display("FAIL basic_latency: got %0d edges, required %0d", lat, c_lat);
        end
        checks++;
        if (result !== e || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: result=%0d busy=%b, required %0d busy=0", result, busy, e);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (result !== e || done !== 1'b1) begin
            errors++;
            $display("FAIL basic_hold: result=%0d done=%b, required %0d done=1", result, done, e);
        end
        pulse_clear();
        checks++;
        if (result !== 128'd0 || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_clear: result=%0h done=%b busy=%b, required 0/0/0", result, done, busy);
        end
    endtask

    task automatic test_products();
        int lat;
        logic [127:0] e;
        logic [63:0]  av[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd1};
        logic [63:0]  bv[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 64'hDEAD_BEEF};
        logic [127:0] ev[3] = '{128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 128'd0, 128'hDEAD_BEEF};
        for (int i = 0; i < 3; i++) begin
            issue(av[i], bv[i], ev[i]);
            wait_done(1'b0, lat);
            e = exp_q.pop_front();
            checks++;
            if (lat !== c_lat || result !== e) begin
                errors++;
                $display("FAIL product_%0d: result=%0h lat=%0d, required %0h lat=%0d", i, result, lat, e, c_lat);
            end
            pulse_clear();
        end
    endtask

    task automatic test_ignore_start();
        int lat;
        logic [127:0] e;
        issue(64'd6, 64'd7, 128'd42);
        wait_done(1'b1, lat);
        e = exp_q.pop_front();
        checks++;
        if (lat !== c_lat || result !== e) begin
            errors++;
            $display("FAIL ignore_exec: result=%0d lat=%0d, required %0d lat=%0d", result, lat, e, c_lat);
        end
        @(negedge clk);
        start = 1'b1; multiplicand = 64'd9; multiplier = 64'd9;
        repeat (5) @(negedge clk);
        checks++;
        if (result !== e || done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ignore_done: result=%0d done=%b busy=%b, required %0d/1/0", result, done, busy, e);
        end
        start = 1'b0;
        pulse_clear();
    endtask

    task automatic test_clear_mid();
        int lat;
        logic [127:0] e;
        issue(64'd11, 64'd13, 128'd143);
        repeat (29) @(negedge clk);
        pulse_clear();
        void'(exp_q.pop_front());
        checks++;
        if (result !== 128'd0 || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL clear_mid: result=%0h done=%b busy=%b, required 0/0/0", result, done, busy);
        end
        issue(64'd5, 64'd7, 128'd35);
        wait_done(1'b0, lat);
        e = exp_q.pop_front();
        checks++;
        if (lat !== c_lat || result !== e) begin
            errors++;
            $display("FAIL clear_restart: result=%0d lat=%0d, required %0d lat=%0d", result, lat, e, c_lat);
        end
        pulse_clear();
        @(negedge clk);
        start = 1'b1; clear = 1'b1; multiplicand = 64'd2; multiplier = 64'd3;
        @(negedge clk);
        start = 1'b0; clear = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL start_clear_busy: busy=%b done=%b, required 0/0", busy, done);
        end
        repeat (c_lat + 6) @(negedge clk);
        checks++;
        if (done !== 1'b0 || result !== 128'd0) begin
            errors++;
            $display("FAIL start_clear_idle: done=%b result=%0h, required 0/0", done, result);
        end
    endtask

    task automatic test_factorial_chain();
        int lat;
        logic [127:0] e;
        logic [127:0] model;
        logic [63:0]  feed;
        model = 128'd20;
        feed  = 64'd20;
        for (int i = 19; i >= 2; i--) begin
            model = model * 128'(i);
            issue(feed, 64'(i), model);
            wait_done(1'b0, lat);
            e = exp_q.pop_front();
            checks++;
            if (lat !== c_lat || result !== e) begin
                errors++;
                $display("FAIL chain_step_%0d: result=%0d lat=%0d, required %0d lat=%0d", i, result, lat, e, c_lat);
            end
            feed = result[63:0];
            pulse_clear();
        end
        checks++;
        if (feed !== 64'd2432902008176640000) begin
            errors++;
            $display("FAIL chain_final: result=%0d, required 2432902008176640000", feed);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        issue(64'd20, 64'd19, 128'd380);
        wait_done(1'b0, lat);
        void'(exp_q.pop_front());
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (result !== 128'd0 || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_done: result=%0h done=%b busy=%b, required 0/0/0", result, done, busy);
        end
        issue(64'd380, 64'd18, 128'd6840);
        repeat (20) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        void'(exp_q.pop_front());
        checks++;
        if (result !== 128'd0 || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_exec: result=%0h done=%b busy=%b, required 0/0/0", result, done, busy);
        end
        repeat (c_lat + 6) @(negedge clk);
        checks++;
        if (done !== 1'b0 || result !== 128'd0) begin
            errors++;
            $display("FAIL reset_stays_idle: done=%b result=%0h, required 0/0", done, result);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_products();
        test_ignore_start();
        test_clear_mid();
        test_factorial_chain();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_facto_multiplier

`default_nettype wire

// File: doc/facto_multiplier.md
Name: facto_multiplier

Overview:
- Iterative unsigned shift-add multiplier; the arithmetic engine directly downstream of the factorial controller.
- Controller drives start/clear and both operands; block returns a full-width product and a done flag.
- Factorial controller loops one multiply per operand decrement. The product feeds back as the next multiplicand, split into result high/low words.
- Fixed, deterministic latency so the controller FSM can rely on done alone.

Parameters:
WIDTH, 64, operand width in bits; product is 2*WIDTH bits
CNT_W, 7, iteration counter width; must satisfy 2**CNT_W > WIDTH

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; dominates every other input
start  input  1  request a multiply; sampled only in IDLE
clear  input  1  synchronous soft clear; aborts any operation, returns to IDLE
multiplicand  input  WIDTH  operand A, latched on accepted start
multiplier  input  WIDTH  operand B, latched on accepted start
result  output  2*WIDTH  registered product A*B, valid while done=1
done  output  1  registered completion flag
busy  output  1  high in EXEC

Behaviour:
- Reset values: result=0, done=0, busy=0, state=IDLE, counter=0, accumulator=0.
- Priority each edge: reset > clear > start > normal stepping.
- States:
  - IDLE: start=1 latches multiplicand into mcand_reg. Loads accumulator acc[2*WIDTH:0] = {(WIDTH+1)'b0, multiplier}. Sets counter=0, moves to EXEC, busy=1.
  - EXEC: one step per cycle. If acc[0]=1, acc[2*WIDTH:WIDTH] = acc[2*WIDTH-1:WIDTH] + mcand_reg (WIDTH+1-bit sum, carry kept). Then acc shifts right logically by 1 and counter increments.
  - EXEC exit: on the step where counter==WIDTH-1, write result=acc_next[2*WIDTH-1:0], set done=1, busy=0, go to DONE.
  - DONE: result and done hold. start is ignored; only clear or reset leaves DONE.
- clear: next edge goes to IDLE with done=0, busy=0, result=0, counter=0. Applies in any state, including mid-EXEC; the partial product is discarded.
- start outside IDLE (EXEC or DONE) is ignored. Operands are not re-sampled.
- start and clear in the same cycle: clear wins; start is not accepted.
- Latency: start accepted at edge k -> done=1 and result valid after edge k+WIDTH (64 cycles at default). No early termination for zero or one operands.
- result never shows partial products; it changes only at completion, clear, or reset.
- Arithmetic: unsigned, exact, no overflow possible (2*WIDTH-bit product). Operand inputs may change freely after start is accepted.
- Reset mid-EXEC: same as clear, and additionally the accumulator is zeroed.
- Controller contract: pulse clear for at least one cycle after consuming result, then assert start for the next step.

Decomposition:
- Shared package facto_pkg: state encoding IDLE=2'b00, EXEC=2'b01, DONE=2'b10; default WIDTH=64; result-word split constants (RES_HI/RES_LO bounds), also used by the controller.
- No sub-module required. The (WIDTH+1)-bit adder stays inline in the EXEC datapath.

Test Plan:
- 3 x 4: start one cycle in IDLE -> busy for 64 cycles, done=1 exactly 64 edges after start, result=128'd12, held until clear.
- 0xFFFF_FFFF_FFFF_FFFF squared -> result=128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001 (carry path exercised).
- 0 x 0x1234 and 1 x 0xDEAD_BEEF -> result=0 and 0xDEAD_BEEF respectively. Latency still 64 cycles.
- Assert start again and change operands during EXEC and during DONE -> ignored; result equals the original product.
- Clear at cycle 30 of EXEC -> next edge done=0, busy=0, result=0. A new start of 5 x 7 then gives 35 after 64 cycles. Same-cycle start+clear -> stays IDLE.
- Factorial chain, with bench acting as controller: multiply 20 down to 2 via clear/start handshakes -> final result=128'd2432902008176640000. Reset asserted mid-chain -> all outputs 0 the next edge.
